pact_lsu_axi_master: RTL

- Single-outstanding bridge from the LSU's request/response port to an AXI4 master (tx) interface. It is the initiator counterpart of the SPM's AXI-slave-to-LPI path.
- Each accepted LSU request becomes exactly one single-beat AXI read or write, and produces exactly one response back to the LSU.
- Placed between PACT_LSU external interfaces and the system interconnect.

---
 rtl/pact_lsu_axi_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pact_lsu_axi_master.sv
// Single-outstanding bridge from the LSU request/response port to an AXI4 master.
// Each accepted request becomes one single-beat AXI read or write and exactly one LSU response.
module pact_lsu_axi_master #(
  parameter int BW_ADDR       = 32,
  parameter int BW_DATA       = 32,
  parameter int BW_STRB       = BW_DATA / 8,
  parameter int BW_AXI_TID    = 4,
  parameter int AXI_TID       = 0,
  parameter int BW_AXI_ALEN   = 8,
  parameter int BW_AXI_ASIZE  = 3,
  parameter int BW_AXI_ABURST = 2,
  parameter int BW_AXI_BRESP  = 2,
  parameter int BW_AXI_RRESP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [BW_ADDR-1:0]       req_addr,
  input  logic [BW_DATA-1:0]       req_wdata,
  input  logic [BW_STRB-1:0]       req_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BW_DATA-1:0]       rsp_rdata,
  output logic                     rsp_error,
  output logic [BW_AXI_TID-1:0]    txawid,
  output logic [BW_AXI_TID-1:0]    txarid,
  output logic [BW_AXI_ALEN-1:0]   txawlen,
  output logic [BW_AXI_ALEN-1:0]   txarlen,
  output logic [BW_AXI_ASIZE-1:0]  txawsize,
  output logic [BW_AXI_ASIZE-1:0]  txarsize,
  output logic [BW_AXI_ABURST-1:0] txawburst,
  output logic [BW_AXI_ABURST-1:0] txarburst,
  output logic [BW_ADDR-1:0]       txawaddr,
  output logic                     txawvalid,
  input  logic                     txawready,
  output logic [BW_AXI_TID-1:0]    txwid,
  output logic [BW_DATA-1:0]       txwdata,
  output logic [BW_STRB-1:0]       txwstrb,
  output logic                     txwlast,
  output logic                     txwvalid,
  input  logic                     txwready,
  input  logic [BW_AXI_BRESP-1:0]  txbresp,
  input  logic                     txbvalid,
  output logic                     txbready,
  output logic [BW_ADDR-1:0]       txaraddr,
  output logic                     txarvalid,
  input  logic                     txarready,
  input  logic [BW_DATA-1:0]       txrdata,
  input  logic [BW_AXI_RRESP-1:0]  txrresp,
  input  logic                     txrlast,
  input  logic                     txrvalid,
  output logic                     txrready
);

  localparam int                 ASIZE      = $clog2(BW_STRB);
  localparam logic [BW_ADDR-1:0] ALIGN_MASK = BW_ADDR'(BW_STRB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RRESP,
    S_RSPOUT
  } state_e;

  state_e               state_q, state_d;
  logic [BW_ADDR-1:0]   addr_q, addr_d;
  logic [BW_DATA-1:0]   wdata_q, wdata_d;
  logic [BW_STRB-1:0]   wstrb_q, wstrb_d;
  logic [BW_DATA-1:0]   rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 misaligned;

  assign misaligned = |(req_addr & ALIGN_MASK);

  assign txawid    = BW_AXI_TID'(AXI_TID);
  assign txarid    = BW_AXI_TID'(AXI_TID);
  assign txwid     = BW_AXI_TID'(AXI_TID);
  assign txawlen   = '0;
  assign txarlen   = '0;
  assign txawsize  = BW_AXI_ASIZE'(ASIZE);
  assign txarsize  = BW_AXI_ASIZE'(ASIZE);
  assign txawburst = BW_AXI_ABURST'(1);
  assign txarburst = BW_AXI_ABURST'(1);
  assign txwlast   = 1'b1;
  assign txawaddr  = addr_q;
  assign txaraddr  = addr_q;
  assign txwdata   = wdata_q;
  assign txwstrb   = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // AW and W each drop on their own handshake; WRESP is entered once both have completed.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    txawvalid = 1'b0;
    txwvalid  = 1'b0;
    txbready  = 1'b0;
    txarvalid = 1'b0;
    txrready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = ~rst;
        if (req_valid && req_ready) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misaligned) begin
            error_d = 1'b1;
            rdata_d = '0;
            state_d = S_RSPOUT;
          end else if (req_write) begin
            state_d = S_WADDR;
          end else begin
            state_d = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        txawvalid = ~aw_done_q;
        txwvalid  = ~w_done_q;
        aw_done_d = aw_done_q | txawready;
        w_done_d  = w_done_q | txwready;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        txbready = 1'b1;
        if (txbvalid) begin
          error_d = (txbresp != '0);
          rdata_d = '0;
          state_d = S_RSPOUT;
        end
      end
      S_RADDR: begin
        txarvalid = 1'b1;
        if (txarready) state_d = S_RRESP;
      end
      S_RRESP: begin
        txrready = 1'b1;
        if (txrvalid) begin
          rdata_d = txrdata;
          error_d = (txrresp != '0) | ~txrlast;
          state_d = S_RSPOUT;
        end
      end
      S_RSPOUT: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
